// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32 datapath.
// Steps lw/sw/addi/add/sub/and/or/beq and counts retired instructions.
module multicycle_control_fsm #(
  parameter int INSTRET_WIDTH   = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic                     funct7_5,
  input  logic                     zero,
  output logic                     PCWrite,
  output logic                     IorD,
  output logic                     MemRead,
  output logic                     MemWrite,
  output logic                     IRWrite,
  output logic                     MemtoReg,
  output logic                     RegWrite,
  output logic                     ALUSrcA,
  output logic [1:0]               ALUSrcB,
  output logic                     PCSource,
  output logic [3:0]               ALUCtl,
  output logic [3:0]               state,
  output logic [INSTRET_WIDTH-1:0] instret,
  output logic                     halted
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_BR_NT     = 4'd10,
    S_HALT      = 4'd11
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_t                   state_q, state_d;
  logic                     skip_q, skip_d;
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
  logic                     is_r, is_addi, is_lw, is_sw, is_beq;
  logic                     retire, adv;
  logic [3:0]               alu_r;

  // Classify the latched instruction and pick the R-type ALU op
  always_comb begin
    is_r    = (opcode == OP_R) &&
              ((funct3 == 3'b000) || (funct3 == 3'b111) ||
               (funct3 == 3'b110));
    is_addi = (opcode == OP_I)  && (funct3 == 3'b000);
    is_lw   = (opcode == OP_LW) && (funct3 == 3'b010);
    is_sw   = (opcode == OP_SW) && (funct3 == 3'b010);
    is_beq  = (opcode == OP_BR) && (funct3 == 3'b000);
    alu_r   = ALU_ADD;
    unique case (1'b1)
      funct3 == 3'b111: alu_r = ALU_AND;
      funct3 == 3'b110: alu_r = ALU_OR;
      funct3 == 3'b000: alu_r = funct7_5 ? ALU_SUB : ALU_ADD;
      default:          alu_r = ALU_ADD;
    endcase
  end

  // Next state, datapath controls and retire strobe
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    retire   = 1'b0;
    adv      = 1'b0;
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSource = 1'b0;
    ALUCtl   = ALU_ADD;
    halted   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        skip_d  = 1'b0;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b10;
        unique case (1'b1)
          is_lw, is_sw: state_d = S_MEM_ADDR;
          is_r:         state_d = S_EXEC_R;
          is_addi:      state_d = S_EXEC_I;
          is_beq:       state_d = S_BRANCH;
          default: begin
            if (HALT_ON_ILLEGAL) begin
              state_d = S_HALT;
            end else begin
              state_d = S_BR_NT;
              skip_d  = 1'b1;
            end
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = is_lw ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        adv      = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        adv      = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUCtl  = alu_r;
        state_d = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        adv      = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUCtl   = ALU_SUB;
        PCSource = 1'b1;
        PCWrite  = zero;
        retire   = zero;
        state_d  = zero ? S_FETCH : S_BR_NT;
      end
      S_BR_NT: begin
        adv     = 1'b1;
        retire  = !skip_q;
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    if (adv) begin
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b01;
      ALUCtl   = ALU_ADD;
      PCSource = 1'b0;
      PCWrite  = 1'b1;
    end
    if (reset) begin
      PCWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
    end
    instret_d = instret_q +
                {{(INSTRET_WIDTH-1){1'b0}}, retire};
  end

  // State, skip flag and retired counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      skip_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed programs plus random
// instruction streams checked against an instruction-level model.
module tb_multicycle_control_fsm;

  localparam int C_ILL  = 0;
  localparam int C_LW   = 1;
  localparam int C_SW   = 2;
  localparam int C_R    = 3;
  localparam int C_ADDI = 4;
  localparam int C_BEQ  = 5;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic clk = 1'b0;
  logic [1:0] reset, funct7_5, zero;
  logic [1:0][6:0] opcode;
  logic [1:0][2:0] funct3;
  logic [1:0] PCWrite, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0] MemtoReg, RegWrite, ALUSrcA, PCSource, halted;
  logic [1:0][1:0] ALUSrcB;
  logic [1:0][3:0] ALUCtl, state;
  logic [1:0][31:0] instret;

  int checks = 0;
  int failures = 0;
  int unsigned exp_ret [2];
  bit hl;

  always #5 clk = ~clk;

  multicycle_control_fsm #(
    .INSTRET_WIDTH(32), .HALT_ON_ILLEGAL(1'b1)
  ) u_halt (
    .clk(clk), .reset(reset[0]), .opcode(opcode[0]),
    .funct3(funct3[0]), .funct7_5(funct7_5[0]), .zero(zero[0]),
    .PCWrite(PCWrite[0]), .IorD(IorD[0]), .MemRead(MemRead[0]),
    .MemWrite(MemWrite[0]), .IRWrite(IRWrite[0]),
    .MemtoReg(MemtoReg[0]), .RegWrite(RegWrite[0]),
    .ALUSrcA(ALUSrcA[0]), .ALUSrcB(ALUSrcB[0]),
    .PCSource(PCSource[0]), .ALUCtl(ALUCtl[0]), .state(state[0]),
    .instret(instret[0]), .halted(halted[0])
  );

  multicycle_control_fsm #(
    .INSTRET_WIDTH(32), .HALT_ON_ILLEGAL(1'b0)
  ) u_skip (
    .clk(clk), .reset(reset[1]), .opcode(opcode[1]),
    .funct3(funct3[1]), .funct7_5(funct7_5[1]), .zero(zero[1]),
    .PCWrite(PCWrite[1]), .IorD(IorD[1]), .MemRead(MemRead[1]),
    .MemWrite(MemWrite[1]), .IRWrite(IRWrite[1]),
    .MemtoReg(MemtoReg[1]), .RegWrite(RegWrite[1]),
    .ALUSrcA(ALUSrcA[1]), .ALUSrcB(ALUSrcB[1]),
    .PCSource(PCSource[1]), .ALUCtl(ALUCtl[1]), .state(state[1]),
    .instret(instret[1]), .halted(halted[1])
  );

  function automatic int classify(logic [6:0] op, logic [2:0] f3);
    if (op == OP_R && (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6))
      return C_R;
    if (op == OP_I && f3 == 3'd0) return C_ADDI;
    if (op == OP_LW && f3 == 3'd2) return C_LW;
    if (op == OP_SW && f3 == 3'd2) return C_SW;
    if (op == OP_BR && f3 == 3'd0) return C_BEQ;
    return C_ILL;
  endfunction

  function automatic logic [3:0] alu_of(logic [2:0] f3, logic f7);
    if (f3 == 3'd7) return 4'b0000;
    if (f3 == 3'd6) return 4'b0001;
    if (f3 == 3'd0 && f7) return 4'b0110;
    return 4'b0010;
  endfunction

  // Expected control word for a named step of the instruction flow.
  function automatic logic [19:0] spec_out(
    int st, logic z, logic [3:0] rc, logic rst);
    logic pcw, iord, mr, mw, irw, m2r, rw, sa, ps, h, pc4;
    logic [1:0] sb;
    logic [3:0] ac;
    {pcw, iord, mr, mw, irw, m2r, rw, sa, ps, h, pc4} = '0;
    sb = 2'b00;
    ac = 4'b0010;
    case (st)
      0: begin mr = 1; irw = 1; end
      1: sb = 2'b10;
      2: begin sa = 1; sb = 2'b10; end
      3: begin iord = 1; mr = 1; end
      4: begin m2r = 1; rw = 1; pc4 = 1; end
      5: begin iord = 1; mw = 1; pc4 = 1; end
      6: begin sa = 1; ac = rc; end
      7: begin sa = 1; sb = 2'b10; end
      8: begin rw = 1; pc4 = 1; end
      9: begin sa = 1; ac = 4'b0110; ps = 1; pcw = z; end
      10: pc4 = 1;
      11: h = 1;
      default: ;
    endcase
    if (pc4) begin
      sa = 0; sb = 2'b01; ac = 4'b0010; ps = 0; pcw = 1;
    end
    if (rst) {pcw, mr, mw, irw, rw} = '0;
    return {pcw, iord, mr, mw, irw, m2r, rw, sa, sb, ps, ac,
            4'(st), h};
  endfunction

  function automatic logic [19:0] dut_vec(int k);
    return {PCWrite[k], IorD[k], MemRead[k], MemWrite[k],
            IRWrite[k], MemtoReg[k], RegWrite[k], ALUSrcA[k],
            ALUSrcB[k], PCSource[k], ALUCtl[k], state[k],
            halted[k]};
  endfunction

  task automatic chk_cycle(int k, int st, logic z,
                           logic [3:0] rc, logic rst);
    logic [19:0] obs, exp;
    obs = dut_vec(k);
    exp = spec_out(st, z, rc, rst);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL ctl u%0d st=%0d observed=%h expected=%h",
             k, st, obs, exp);
    end
    checks++;
    assert (instret[k] === exp_ret[k]) else begin
      failures++;
      $error("FAIL instret u%0d observed=%0d expected=%0d",
             k, instret[k], exp_ret[k]);
    end
  endtask

  task automatic check_eq(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(int k, int n);
    reset[k] = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      exp_ret[k] = 0;
      if (i < n - 1) begin
        zero[k] = 1'($urandom);
        #2;
        chk_cycle(k, 0, zero[k], 4'b0010, 1'b1);
      end
    end
    reset[k] = 1'b0;
  endtask

  // Runs one instruction from FETCH; starts and ends at posedge+1.
  task automatic run_instr(int k, logic [6:0] op, logic [2:0] f3,
                           logic f7, bit zb, int abort,
                           output bit halt_now);
    int path[$];
    int cls;
    logic z;
    logic [3:0] rc;
    cls = classify(op, f3);
    rc = alu_of(f3, f7);
    path = '{0, 1};
    case (cls)
      C_LW:   path = '{0, 1, 2, 3, 4};
      C_SW:   path = '{0, 1, 2, 5};
      C_R:    path = '{0, 1, 6, 8};
      C_ADDI: path = '{0, 1, 7, 8};
      C_BEQ:  path = zb ? '{0, 1, 9} : '{0, 1, 9, 10};
      default: path = (k == 0) ? '{0, 1, 11} : '{0, 1, 10};
    endcase
    opcode[k] = op;
    funct3[k] = f3;
    funct7_5[k] = f7;
    halt_now = (path[path.size() - 1] == 11);
    for (int i = 0; i < path.size(); i++) begin
      z = (path[i] == 9) ? zb : 1'($urandom);
      zero[k] = z;
      if (i == abort) reset[k] = 1'b1;
      #2;
      chk_cycle(k, path[i], z, rc, i == abort);
      @(posedge clk); #1;
      if (i == abort) begin
        reset[k] = 1'b0;
        exp_ret[k] = 0;
        halt_now = 1'b0;
        return;
      end
    end
    if (cls != C_ILL) exp_ret[k]++;
  endtask

  task automatic hold_halt(int k, int n);
    for (int i = 0; i < n; i++) begin
      zero[k] = 1'($urandom);
      #2;
      chk_cycle(k, 11, zero[k], 4'b0010, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_run(int k, int n);
    logic [6:0] op;
    logic [2:0] f3;
    logic f7;
    bit h;
    for (int i = 0; i < n; i++) begin
      f7 = 1'b0;
      case ($urandom_range(0, 9))
        0: begin op = OP_LW; f3 = 3'd2; end
        1: begin op = OP_SW; f3 = 3'd2; end
        2: begin op = OP_I;  f3 = 3'd0; end
        3: begin op = OP_R;  f3 = 3'd0; end
        4: begin op = OP_R;  f3 = 3'd0; f7 = 1'b1; end
        5: begin op = OP_R;  f3 = 3'd7; end
        6: begin op = OP_R;  f3 = 3'd6; end
        7, 8: begin op = OP_BR; f3 = 3'd0; end
        default: begin
          op = 7'($urandom);
          f3 = 3'($urandom);
          f7 = 1'($urandom);
        end
      endcase
      run_instr(k, op, f3, f7, 1'($urandom), -1, h);
      if (h) begin
        hold_halt(k, 3);
        do_reset(k, 2);
      end
    end
  endtask

  initial begin
    reset = 2'b11;
    zero = '0;
    opcode = '0;
    funct3 = '0;
    funct7_5 = '0;
    exp_ret[0] = 0;
    exp_ret[1] = 0;
    do_reset(0, 3);

    run_instr(0, OP_I,  3'd0, 1'b0, 1'b0, -1, hl);
    run_instr(0, OP_LW, 3'd2, 1'b0, 1'b0, -1, hl);
    run_instr(0, OP_R,  3'd0, 1'b0, 1'b0, -1, hl);
    run_instr(0, OP_R,  3'd0, 1'b1, 1'b0, -1, hl);
    run_instr(0, OP_BR, 3'd0, 1'b0, 1'b1, -1, hl);
    check_eq("prog_state", int'(state[0]), 0);
    check_eq("prog_instret", int'(instret[0]), 5);
    run_instr(0, OP_R,  3'd6, 1'b0, 1'b0, -1, hl);
    check_eq("or_instret", int'(instret[0]), 6);
    run_instr(0, 7'd0, 3'd0, 1'b0, 1'b0, -1, hl);
    hold_halt(0, 4);
    check_eq("halt_instret", int'(instret[0]), 6);
    do_reset(0, 2);

    run_instr(0, OP_BR, 3'd0, 1'b0, 1'b0, -1, hl);
    run_instr(0, OP_SW, 3'd2, 1'b0, 1'b0, -1, hl);
    check_eq("sw_instret", int'(instret[0]), 2);
    run_instr(0, OP_LW, 3'd2, 1'b0, 1'b0, 3, hl);
    check_eq("abort_state", int'(state[0]), 0);
    run_instr(0, OP_I,  3'd0, 1'b0, 1'b0, -1, hl);
    rand_run(0, 60);
    reset[0] = 1'b1;

    do_reset(1, 3);
    run_instr(1, OP_I, 3'd0, 1'b0, 1'b0, -1, hl);
    run_instr(1, 7'd0, 3'd0, 1'b0, 1'b0, -1, hl);
    check_eq("skip_instret", int'(instret[1]), 1);
    check_eq("skip_state", int'(state[1]), 0);
    rand_run(1, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
